// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: load formats, load FSM states
// and the word-crossing test.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic f3_is_legal(input logic [F3_W-1:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // True when the access touches bytes in the following word.
  function automatic logic is_crossing(input logic [F3_W-1:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off == 2'd3;
      F3_LW:         return off != 2'd0;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ctrl_ld_converter.sv
// Load converter: selects the byte/half at the given offset and sign- or
// zero-extends it according to the RV32I load format.
module ld_converter
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      offset_i,
  input  logic [F3_W-1:0] funct3_i,
  output logic [XLEN-1:0] data_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = data_i >> {offset_i, 3'b000};
    data_c  = '0;
    case (funct3_i)
      F3_LB:   data_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   data_c = shifted;
      F3_LBU:  data_c = {24'd0, shifted[7:0]};
      F3_LHU:  data_c = {16'd0, shifted[15:0]};
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_load_ctrl.sv
// Load sequencer: issues one or two word reads per load, merges a
// word-crossing pair and returns the extended result over valid/ready.
module lsu_load_ctrl
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [F3_W-1:0] req_funct3,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            busy
);

  localparam int unsigned WA_W = XLEN - 2;

  state_e          state_q, state_d;
  logic [WA_W-1:0] waddr_q, waddr_d;
  logic [1:0]      off_q, off_d;
  logic [F3_W-1:0] f3_q, f3_d;
  logic            cross_q, cross_d;
  logic [XLEN-1:0] w0_q, w0_d;
  logic            req_ready_q, req_ready_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            busy_q, busy_d;

  logic            legal_c, cross_req_c;
  logic [2*XLEN-1:0] pair_c;
  logic [XLEN-1:0] merged_c, ext_c;

  // Merge the word pair on the fly so the result is registered on the final ack.
  always_comb begin
    legal_c     = f3_is_legal(req_funct3);
    cross_req_c = is_crossing(req_funct3, req_addr[1:0]);
    pair_c      = (state_q == RD1) ? {mem_rdata, w0_q} : {{XLEN{1'b0}}, mem_rdata};
    merged_c    = XLEN'(pair_c >> {off_q, 3'b000});
  end

  ld_converter u_conv (
    .data_i   (merged_c),
    .offset_i (2'b00),
    .funct3_i (f3_q),
    .data_c   (ext_c)
  );

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    off_d        = off_q;
    f3_d         = f3_q;
    cross_d      = cross_q;
    w0_d         = w0_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          waddr_d = req_addr[XLEN-1:2];
          off_d   = req_addr[1:0];
          f3_d    = req_funct3;
          cross_d = cross_req_c;
          if (!legal_c || (cross_req_c && !ALLOW_MISALIGNED)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d    = RD0;
            mem_req_d  = 1'b1;
            mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
          end
        end
      end
      RD0: begin
        if (mem_ack) begin
          w0_d = mem_rdata;
          if (cross_q) begin
            state_d    = RD1;
            mem_addr_d = {waddr_q + WA_W'(1), 2'b00};
          end else begin
            state_d      = RESP;
            mem_req_d    = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = ext_c;
          end
        end
      end
      RD1: begin
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = ext_c;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      waddr_q      <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      cross_q      <= 1'b0;
      w0_q         <= '0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      cross_q      <= cross_d;
      w0_q         <= w0_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule
